trx_sequencer: RTL and testbench
================================

TRX_SEQUENCER -- requirements
Module: trx_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max idle cycles allowed while waiting on FIFO data (TX) or the sync word (RX).
REQ-002 SHALL have parameter PREAMBLE_LEN, default 8, preamble/sync-word length in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of inClock.
REQ-004 SHALL have port inClock, input, 1, clock.
REQ-005 SHALL have port inReset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port inStart, input, 1, frame start pulse.
REQ-007 SHALL have port inMode, input, 1, direction: 0 = TX, 1 = RX; sampled with inStart.
REQ-008 SHALL have port inLength, input, 8, payload bits; sampled with inStart.
REQ-009 SHALL have port inAbort, input, 1, abort the current frame.
REQ-010 SHALL have ports inFifoEmpty (input, 1) and inFifoData (input, 1), the inFIFO status and data bit.
REQ-011 SHALL have port outFifoReadEnable, output, 1, inFIFO read strobe.
REQ-012 SHALL have ports inCoderReady (input, 1), outCoderData (output, 1) and outCoderEmpty (output, 1), the modulator bit handshake.
REQ-013 SHALL have ports inCdrFlag (input, 1) and inCdrData (input, 1), the recovered-bit strobe and data.
REQ-014 SHALL have ports outOutFifoWriteEnable (output, 1) and outOutFifoData (output, 1), the outFIFO write side.
REQ-015 SHALL have ports outBusy (output, 1), outDone (output, 1), outError (output, 1) and outBitCount (output, 8), for frame status.

Function
REQ-016 SHALL implement the FSM states IDLE, TX_PRE, TX_DATA, RX_SYNC, RX_DATA and DONE.
REQ-017 IDLE: on inStart with inLength != 0, SHALL latch inLength and go to TX_PRE (inMode = 0) or RX_SYNC (inMode = 1).
REQ-018 IDLE: on inStart with inLength == 0, SHALL pulse outError for 1 cycle and remain in IDLE.
REQ-019 TX_PRE: each cycle with inCoderReady = 1, SHALL drive outCoderData with the next preamble bit (MSB first) and outCoderEmpty = 0; after PREAMBLE_LEN bits, SHALL go to TX_DATA.
REQ-020 TX_DATA: outFifoReadEnable SHALL equal inCoderReady AND NOT inFifoEmpty, combinationally in the same cycle.
REQ-021 TX_DATA: outCoderData SHALL equal inFifoData, and outCoderEmpty SHALL equal inFifoEmpty.
REQ-022 TX_DATA: outBitCount SHALL increment on each read; the state SHALL go to DONE when the count reaches the latched length.
REQ-023 RX_SYNC: on each inCdrFlag, SHALL shift inCdrData into a PREAMBLE_LEN-bit register; when the register equals the sync word, SHALL go to RX_DATA; no outFIFO writes SHALL occur in this state.
REQ-024 RX_DATA: outOutFifoWriteEnable SHALL equal inCdrFlag and outOutFifoData SHALL equal inCdrData, combinationally.
REQ-025 RX_DATA: outBitCount SHALL increment on each write; the state SHALL go to DONE at the latched length.
REQ-026 DONE: SHALL pulse outDone for exactly 1 cycle, then go to IDLE.
REQ-027 outBusy SHALL be 1 in every state except IDLE.
REQ-028 outBitCount SHALL clear on an accepted start and hold its value in IDLE.
REQ-029 Timeout: a 16-bit counter SHALL clear on every bit transfer and increment in TX_DATA (FIFO empty) and RX_SYNC; on reaching TIMEOUT_CYCLES, SHALL pulse outError for 1 cycle and go to IDLE without outDone.
REQ-030 inAbort in any non-IDLE state SHALL force IDLE on the next edge, with no outDone and no outError.
REQ-031 inAbort together with inStart in IDLE: abort SHALL win and the start SHALL be ignored.
REQ-032 inStart while outBusy = 1 SHALL be ignored.
REQ-033 All strobes (outFifoReadEnable, outOutFifoWriteEnable) SHALL be 0 in IDLE and DONE.

Reset
REQ-034 When inReset = 1 at a clock edge, the block SHALL enter IDLE and clear all counters and the shift register, mid-frame included.
REQ-035 During and after reset, outputs SHALL be: outBusy = 0, outDone = 0, outError = 0, outBitCount = 0, both strobes = 0, outCoderData = 0, outCoderEmpty = 1.

Configuration
REQ-036 Macro TRX_SEQ_PREAMBLE_EN SHALL select preamble behaviour.
REQ-037 When TRX_SEQ_PREAMBLE_EN is defined, TX_PRE and RX_SYNC SHALL operate as in REQ-019 and REQ-023.
REQ-038 When TRX_SEQ_PREAMBLE_EN is undefined, the TX start SHALL go directly to TX_DATA, the RX start SHALL go directly to RX_DATA, and no preamble/sync logic SHALL be synthesized.

Structure
REQ-039 Package trx_seq_pkg SHALL hold the state enum typedef, the sync word constant SYNC_WORD = 8'b01010101, and the counter width constant (16).
REQ-040 The timeout counter SHALL be the sub-module trx_seq_timer, with clear, enable and expired ports.

Verification
REQ-041 Macro on, TX, inLength = 4, FIFO holding 1011, inCoderReady always 1 -> outCoderData sequence 01010101 then 1011; outDone on the cycle after the 12th bit; outBitCount = 4.
REQ-042 RX, inLength = 3, CDR bits 1,1,0,1,0,1,0,1,0,1 then 1,0,1 -> exactly 3 writes with data 101; outDone = 1 once.
REQ-043 TX with the FIFO empty for 4096 cycles in TX_DATA -> outError pulse of 1 cycle, IDLE, outDone never asserted.
REQ-044 inAbort in TX_DATA after 2 bits -> IDLE next cycle; outBusy = 0, outBitCount = 2, no outDone and no outError.
REQ-045 inStart with inLength = 0 -> outError = 1 for 1 cycle, outBusy stays 0; inReset asserted mid RX_DATA -> all outputs at their reset values next cycle.
REQ-046 Macro off, TX, inLength = 2 -> first coder bit is FIFO data, with no preamble.

Source files
------------

// File: rtl/trx_seq_pkg.sv
// Shared types and constants for the TX/RX frame sequencer.
// The preamble/sync feature is selected by the TRX_SEQ_PREAMBLE_EN macro in trx_sequencer.
package trx_seq_pkg;

  localparam int CNT_W = 16;
  localparam logic [7:0] SYNC_WORD = 8'b01010101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_PRE,
    ST_TX_DATA,
    ST_RX_SYNC,
    ST_RX_DATA,
    ST_DONE
  } trx_state_e;

  // Bit idx of the sync pattern; the 8-bit word repeats for longer preambles.
  function automatic logic sync_bit(input int idx);
    return SYNC_WORD[idx % 8];
  endfunction

endpackage

// File: rtl/trx_seq_timer.sv
// Idle-cycle watchdog: clear wins over enable; expired_o flags the cycle whose
// increment would make the count reach LIMIT.
module trx_seq_timer
  import trx_seq_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = enable_i & ~clear_i & (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trx_sequencer.sv
// Frame sequencer: TX pulls payload bits from the inFIFO into the coder, RX pushes
// CDR bits into the outFIFO. Define TRX_SEQ_PREAMBLE_EN to add TX preamble / RX sync.
// Handshakes: every strobe below is a same-cycle transfer -- a TX bit moves when
// inCoderReady=1 and the source is non-empty, an RX bit moves when inCdrFlag=1.
module trx_sequencer
  import trx_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int PREAMBLE_LEN   = 8
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic       inMode,
  input  logic [7:0] inLength,
  input  logic       inAbort,
  input  logic       inFifoEmpty,
  input  logic       inFifoData,
  output logic       outFifoReadEnable,
  input  logic       inCoderReady,
  output logic       outCoderData,
  output logic       outCoderEmpty,
  input  logic       inCdrFlag,
  input  logic       inCdrData,
  output logic       outOutFifoWriteEnable,
  output logic       outOutFifoData,
  output logic       outBusy,
  output logic       outDone,
  output logic       outError,
  output logic [7:0] outBitCount,
  output trx_state_e outDbgState
);

  if (PREAMBLE_LEN < 2 || PREAMBLE_LEN > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_param
    $error("trx_sequencer: PREAMBLE_LEN or TIMEOUT_CYCLES out of range");
  end

`ifdef TRX_SEQ_PREAMBLE_EN
  localparam trx_state_e TX_ENTRY = ST_TX_PRE;
  localparam trx_state_e RX_ENTRY = ST_RX_SYNC;
  localparam int PRE_W = $clog2(PREAMBLE_LEN);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PREAMBLE_LEN - 1);

  function automatic logic [PREAMBLE_LEN-1:0] build_sync();
    logic [PREAMBLE_LEN-1:0] v;
    for (int i = 0; i < PREAMBLE_LEN; i++) v[i] = sync_bit(i);
    return v;
  endfunction

  localparam logic [PREAMBLE_LEN-1:0] SYNC_PAT = build_sync();

  logic [PRE_W-1:0]        pre_idx_q, pre_idx_d;
  logic [PREAMBLE_LEN-1:0] shift_q, shift_d;
`else
  localparam trx_state_e TX_ENTRY = ST_TX_DATA;
  localparam trx_state_e RX_ENTRY = ST_RX_DATA;
`endif

  trx_state_e state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic       error_q, error_d;
  logic       counting, tmr_en, tmr_clear, tmr_expired;

  assign outFifoReadEnable     = (state_q == ST_TX_DATA) & inCoderReady & ~inFifoEmpty;
  assign outOutFifoWriteEnable = (state_q == ST_RX_DATA) & inCdrFlag;

  // The watchdog only runs while waiting on FIFO data or on the sync word.
  assign counting  = (state_q == ST_TX_DATA) | (state_q == ST_RX_SYNC);
  assign tmr_en    = ((state_q == ST_TX_DATA) & inFifoEmpty) | (state_q == ST_RX_SYNC);
  assign tmr_clear = ~counting | outFifoReadEnable | ((state_q == ST_RX_SYNC) & inCdrFlag);

  trx_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (inClock),
    .rst_i    (inReset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    bit_cnt_d      = bit_cnt_q;
    error_d        = 1'b0;
    outCoderData   = 1'b0;
    outCoderEmpty  = 1'b1;
    outOutFifoData = 1'b0;
`ifdef TRX_SEQ_PREAMBLE_EN
    pre_idx_d      = pre_idx_q;
    shift_d        = shift_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (inStart && !inAbort) begin
          if (inLength == 8'd0) begin
            error_d = 1'b1;
          end else begin
            len_d     = inLength;
            bit_cnt_d = 8'd0;
            state_d   = inMode ? RX_ENTRY : TX_ENTRY;
`ifdef TRX_SEQ_PREAMBLE_EN
            pre_idx_d = PRE_TOP;
            shift_d   = '0;
`endif
          end
        end
      end
`ifdef TRX_SEQ_PREAMBLE_EN
      ST_TX_PRE: begin
        // pre_idx_q walks the pattern from its MSB down to bit 0.
        outCoderData  = SYNC_PAT[pre_idx_q];
        outCoderEmpty = 1'b0;
        if (inCoderReady) begin
          if (pre_idx_q == '0) state_d = ST_TX_DATA;
          else pre_idx_d = pre_idx_q - PRE_W'(1);
        end
      end
      ST_RX_SYNC: begin
        if (inCdrFlag) begin
          shift_d = {shift_q[PREAMBLE_LEN-2:0], inCdrData};
          if (shift_d == SYNC_PAT) state_d = ST_RX_DATA;
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
`endif
      ST_TX_DATA: begin
        outCoderData  = inFifoData;
        outCoderEmpty = inFifoEmpty;
        if (outFifoReadEnable) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_d == len_q) state_d = ST_DONE;
        end else if (tmr_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_RX_DATA: begin
        outOutFifoData = inCdrData;
        if (inCdrFlag) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_d == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort drops the frame silently and freezes the bit count where it stood.
    if (inAbort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      bit_cnt_d = bit_cnt_q;
      error_d   = 1'b0;
    end
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      bit_cnt_q <= 8'd0;
      error_q   <= 1'b0;
`ifdef TRX_SEQ_PREAMBLE_EN
      pre_idx_q <= '0;
      shift_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      error_q   <= error_d;
`ifdef TRX_SEQ_PREAMBLE_EN
      pre_idx_q <= pre_idx_d;
      shift_q   <= shift_d;
`endif
    end
  end

  assign outBusy     = (state_q != ST_IDLE);
  assign outDone     = (state_q == ST_DONE);
  assign outError    = error_q;
  assign outBitCount = bit_cnt_q;
  assign outDbgState = state_q;

endmodule

// File: tb/tb_trx_sequencer.sv
// Directed bench for trx_sequencer; works with TRX_SEQ_PREAMBLE_EN defined or not.
module tb_trx_sequencer;
  import trx_seq_pkg::*;

  logic       inClock = 1'b0;
  logic       inReset, inStart, inMode, inAbort;
  logic [7:0] inLength;
  logic       inFifoEmpty, inFifoData, outFifoReadEnable;
  logic       inCoderReady, outCoderData, outCoderEmpty;
  logic       inCdrFlag, inCdrData, outOutFifoWriteEnable, outOutFifoData;
  logic       outBusy, outDone, outError;
  logic [7:0] outBitCount;
  trx_state_e outDbgState;

`ifdef TRX_SEQ_PREAMBLE_EN
  localparam int PRE = 8;
`else
  localparam int PRE = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [0:0] exp_q[$];
  logic [0:0] fifo_q[$];
  int rx_done, rx_wr;
  logic [7:0] pre_bits;

  trx_sequencer dut (
    .inClock(inClock), .inReset(inReset), .inStart(inStart), .inMode(inMode),
    .inLength(inLength), .inAbort(inAbort), .inFifoEmpty(inFifoEmpty),
    .inFifoData(inFifoData), .outFifoReadEnable(outFifoReadEnable),
    .inCoderReady(inCoderReady), .outCoderData(outCoderData),
    .outCoderEmpty(outCoderEmpty), .inCdrFlag(inCdrFlag), .inCdrData(inCdrData),
    .outOutFifoWriteEnable(outOutFifoWriteEnable), .outOutFifoData(outOutFifoData),
    .outBusy(outBusy), .outDone(outDone), .outError(outError),
    .outBitCount(outBitCount), .outDbgState(outDbgState)
  );

  // clock / reset
  always #5 inClock = ~inClock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClock);
    #1;
  endtask

  task automatic drive_fifo();
    inFifoEmpty = (fifo_q.size() == 0);
    inFifoData  = (fifo_q.size() == 0) ? 1'b0 : fifo_q[0];
  endtask

  task automatic rx_monitor();
    if (outDone) rx_done++;
    if (outOutFifoWriteEnable) begin
      rx_wr++;
      if (exp_q.size() > 0) chk("rx_data", outOutFifoData, exp_q.pop_front());
      else chk("rx_extra_write", rx_wr, 3);
    end
  endtask

  task automatic rx_feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      inCdrFlag = 1'b1;
      inCdrData = bits[n-1-i];
      #1;
      rx_monitor();
      tick();
      inCdrFlag = 1'b0;
      inCdrData = 1'b0;
      #1;
      rx_monitor();
      tick();
    end
  endtask

  initial begin
    int done_cyc, last_cyc, nbits, nreads, err_seen, cycles, got, done_seen, reached;
    logic [15:0] rx_bits;
    int rx_n;

    pre_bits = 8'b01010101;
    inReset = 1'b1; inStart = 1'b0; inMode = 1'b0; inAbort = 1'b0; inLength = 8'd0;
    inCoderReady = 1'b0; inCdrFlag = 1'b0; inCdrData = 1'b0;
    drive_fifo();
    repeat (3) tick();
    #1;
    chk("rst_busy", outBusy, 0);
    chk("rst_done", outDone, 0);
    chk("rst_error", outError, 0);
    chk("rst_bitcount", outBitCount, 0);
    chk("rst_rd_strobe", outFifoReadEnable, 0);
    chk("rst_wr_strobe", outOutFifoWriteEnable, 0);
    chk("rst_coder_data", outCoderData, 0);
    chk("rst_coder_empty", outCoderEmpty, 1);
    chk("rst_state", 32'(outDbgState), 32'(ST_IDLE));
    inReset = 1'b0;
    tick();

    // zero-length start: one-cycle error, never busy
    inStart = 1'b1; inLength = 8'd0;
    tick();
    inStart = 1'b0;
    #1;
    chk("zero_len_error", outError, 1);
    chk("zero_len_busy", outBusy, 0);
    tick();
    #1;
    chk("zero_len_error_pulse", outError, 0);

    // abort together with start in IDLE: start ignored
    inStart = 1'b1; inAbort = 1'b1; inLength = 8'd4; inMode = 1'b0;
    tick();
    inStart = 1'b0; inAbort = 1'b0;
    #1;
    chk("abort_start_busy", outBusy, 0);
    chk("abort_start_error", outError, 0);

    // TX frame, payload 1011, coder always ready
    fifo_q = {1'b1, 1'b0, 1'b1, 1'b1};
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(pre_bits[7-i]);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    inCoderReady = 1'b1; inMode = 1'b0; inLength = 8'd4; inStart = 1'b1;
    drive_fifo();
    #1;
    chk("tx_start_not_busy_yet", outBusy, 0);
    tick();
    done_cyc = -1; last_cyc = -1; nbits = 0; nreads = 0; err_seen = 0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      inStart  = (c == 0);   // a second start (zero length) while busy must be ignored
      inLength = 8'd0;
      drive_fifo();
      #1;
      if (outError) err_seen = 1;
      if (outDone) done_cyc = c;
      else if (!outCoderEmpty) begin
        nbits++;
        last_cyc = c;
        if (exp_q.size() > 0) chk("tx_bit", outCoderData, exp_q.pop_front());
        else chk("tx_extra_bit", nbits, PRE + 4);
      end
      if (outFifoReadEnable) begin
        nreads++;
        void'(fifo_q.pop_front());
      end
      tick();
    end
    #1;
    chk("tx_done_seen", done_cyc >= 0, 1);
    chk("tx_done_latency", done_cyc, last_cyc + 1);
    chk("tx_nbits", nbits, PRE + 4);
    chk("tx_reads", nreads, 4);
    chk("tx_no_error", err_seen, 0);
    chk("tx_bitcount", outBitCount, 4);
    chk("tx_idle_after_done", outBusy, 0);
    chk("tx_done_pulse", outDone, 0);

    // RX frame, length 3, payload 101 after the sync word
`ifdef TRX_SEQ_PREAMBLE_EN
    rx_bits = 16'b0001_1010_1010_1101;  // 1,1,0,1,0,1,0,1,0,1 then 1,0,1
    rx_n = 13;
`else
    rx_bits = 16'b0000_0000_0000_0101;
    rx_n = 3;
`endif
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    rx_done = 0; rx_wr = 0;
    inMode = 1'b1; inLength = 8'd3; inStart = 1'b1;
    tick();
    inStart = 1'b0;
    rx_feed(rx_bits, rx_n);
    for (int i = 0; i < 4; i++) begin
      #1;
      rx_monitor();
      tick();
    end
    #1;
    chk("rx_writes", rx_wr, 3);
    chk("rx_done_once", rx_done, 1);
    chk("rx_bitcount", outBitCount, 3);
    chk("rx_idle", outBusy, 0);

    // abort in TX_DATA after two bits
    fifo_q = {1'b1, 1'b1, 1'b0, 1'b0};
    inMode = 1'b0; inLength = 8'd4; inStart = 1'b1; inCoderReady = 1'b1;
    drive_fifo();
    tick();
    inStart = 1'b0;
    reached = 0;
    for (int c = 0; c < 40 && reached == 0; c++) begin
      inCoderReady = 1'b1;
      drive_fifo();
      #1;
      if (outBitCount == 8'd2) reached = 1;
      else begin
        if (outFifoReadEnable) void'(fifo_q.pop_front());
        tick();
      end
    end
    chk("ab_reached_two_bits", reached, 1);
    chk("ab_state_before", 32'(outDbgState), 32'(ST_TX_DATA));
    inCoderReady = 1'b0; inAbort = 1'b1;
    tick();
    inAbort = 1'b0; inCoderReady = 1'b1;
    drive_fifo();
    #1;
    chk("ab_busy", outBusy, 0);
    chk("ab_bitcount", outBitCount, 2);
    chk("ab_done", outDone, 0);
    chk("ab_error", outError, 0);
    chk("ab_idle_rd_strobe", outFifoReadEnable, 0);
    tick();

    // timeout with the FIFO empty
    fifo_q.delete();
    inMode = 1'b0; inLength = 8'd4; inStart = 1'b1; inCoderReady = 1'b1;
    drive_fifo();
    tick();
    inStart = 1'b0;
    cycles = 0; got = 0; done_seen = 0;
    for (int c = 0; c < 5000 && got == 0; c++) begin
      drive_fifo();
      #1;
      if (outDone) done_seen = 1;
      if (outError) got = 1;
      else begin
        cycles++;
        tick();
      end
    end
    chk("to_fired", got, 1);
    chk("to_cycles", cycles, 4096 + PRE);
    chk("to_busy", outBusy, 0);
    chk("to_no_done", done_seen, 0);
    tick();
    #1;
    chk("to_error_pulse", outError, 0);

    // reset in the middle of RX_DATA
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    rx_done = 0; rx_wr = 0;
    inMode = 1'b1; inLength = 8'd8; inStart = 1'b1;
    tick();
    inStart = 1'b0;
`ifdef TRX_SEQ_PREAMBLE_EN
    rx_feed(16'b0000_0001_0101_0111, 10);
`else
    rx_feed(16'b0000_0000_0000_0011, 2);
`endif
    #1;
    chk("mid_rx_state", 32'(outDbgState), 32'(ST_RX_DATA));
    chk("mid_rx_bitcount", outBitCount, 2);
    inReset = 1'b1; inCdrFlag = 1'b1; inCdrData = 1'b1;
    tick();
    #1;
    chk("mid_rst_busy", outBusy, 0);
    chk("mid_rst_done", outDone, 0);
    chk("mid_rst_error", outError, 0);
    chk("mid_rst_bitcount", outBitCount, 0);
    chk("mid_rst_wr_strobe", outOutFifoWriteEnable, 0);
    chk("mid_rst_rd_strobe", outFifoReadEnable, 0);
    chk("mid_rst_coder_data", outCoderData, 0);
    chk("mid_rst_coder_empty", outCoderEmpty, 1);
    inReset = 1'b0; inCdrFlag = 1'b0; inCdrData = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
